updown_mod_counter: RTL

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 86 ++++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Up/down counter over the runtime range 0..limit with wrap or saturate at the bounds.
// count, wrap and ovf are registered; at_max and at_zero are decoded from count.
module updown_mod_counter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             ovf,
   output logic             at_max,
   output logic             at_zero
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam bit               SAT = (SATURATE != 0);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (load) begin
         count_d = (load_val > limit) ? limit : load_val;
      end else if (en) begin
         if (up) begin
            if (count_q < limit) begin
               count_d = count_q + ONE;
            end else begin
               ovf_d = 1'b1;
               if (SAT) begin
                  count_d = limit;
               end else begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end
            end
         end else begin
            // A count stranded above a lowered limit is pulled back without flagging a bound hit.
            if (count_q > limit) begin
               count_d = limit;
            end else if (count_q == '0) begin
               ovf_d = 1'b1;
               if (!SAT) begin
                  count_d = limit;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = count_q - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count   = count_q;
   assign wrap    = wrap_q;
   assign ovf     = ovf_q;
   assign at_max  = (count_q == limit);
   assign at_zero = (count_q == '0);

endmodule
